dma_ring_sched: RTL and testbench
=================================

// Module: dma_ring_sched
// PURPOSE
//  Schedules buffer commands for the simple_dma engine that moves CIS pixel FIFO data into SDRAM.
//  Splits an SDRAM region into CFG_NUM_BUFS equal buffers and issues START/START_ADR/BUF_SIZE
//  commands, keeping at most CMD_DEPTH commands outstanding. Counts completed buffers from DMA_DONE_CNT.
//  Never overwrites a buffer that software has not released. Replaces the software polling loop.
// PARAMETERS
//  ADDR_W     28  SDRAM word address width (128-bit words)
//  CNT_W      16  width of buffer counters and of DMA_DONE_CNT
//  CMD_DEPTH  1   max commands outstanding in simple_dma (issued, not yet done)
// PORTS
//  CLK             in   1       system/bus clock; all ports synchronous to it
//  RST_N           in   1       asynchronous active-low reset
//  SRST            in   1       synchronous soft reset (linux reset); same effect as RST_N
//  CFG_ENABLE      in   1       run request; rising edge in IDLE starts a session
//  CFG_CYCLIC      in   1       1: ring wraps forever; 0: stop after CFG_NUM_BUFS buffers
//  CFG_BASE        in   ADDR_W  first buffer word address
//  CFG_BUF_SIZE    in   ADDR_W  buffer size in 128-bit words (line = 972 words)
//  CFG_NUM_BUFS    in   CNT_W   buffers in ring
//  SW_RELEASE      in   1       pulse: software consumed SW_RELEASE_CNT buffers
//  SW_RELEASE_CNT  in   CNT_W   buffers released with SW_RELEASE
//  DMA_START       out  1       one-cycle command pulse to simple_dma START
//  DMA_START_ADR   out  ADDR_W  buffer address, valid with DMA_START, held until next start
//  DMA_BUF_SIZE    out  ADDR_W  latched CFG_BUF_SIZE, held
//  DMA_DONE_CNT    in   CNT_W   simple_dma free-running completed-buffer counter (wraps)
//  FILLED          out  CNT_W   buffers completed, not yet released
//  WR_IDX          out  CNT_W   ring index of next buffer to issue
//  DONE_TOTAL      out  CNT_W   buffers completed this session (wraps)
//  BUSY            out  1       state != IDLE
//  FINISHED        out  1       non-cyclic session complete
//  STALL           out  1       issue blocked only because ring is full
//  ERR             out  1       sticky: bad release/done count or NUM_BUFS==0; cleared by reset/new session
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; done_prev captured from DMA_DONE_CNT at first cycle after reset.
//  States:
//   IDLE   -> ISSUE on CFG_ENABLE 0->1.
//     Latch CFG_BASE/BUF_SIZE/NUM_BUFS/CYCLIC and clear counters/ERR. Snapshot done_prev=DMA_DONE_CNT.
//     If NUM_BUFS==0: set ERR and stay IDLE.
//   ISSUE  -> GAP when a command is issued. Issue condition:
//     in_flight<CMD_DEPTH and FILLED+in_flight<NUM_BUFS and (CYCLIC or issued<NUM_BUFS).
//   GAP    -> ISSUE next cycle; guarantees >=1 idle cycle between DMA_START pulses.
//   DRAIN  entered from ISSUE/GAP when CFG_ENABLE=0; no issue; -> IDLE when in_flight==0.
//   DONE   entered when !CYCLIC and DONE_TOTAL==NUM_BUFS; FINISHED=1; -> IDLE on CFG_ENABLE=0.
//  Issue cycle: DMA_START=1, DMA_START_ADR=cur_adr, in_flight++, issued++.
//   WR_IDX++; cur_adr+=BUF_SIZE; on WR_IDX==NUM_BUFS-1 wrap WR_IDX=0, cur_adr=BASE. No multiplier.
//  Done tracking (every cycle, all states): delta=DMA_DONE_CNT-done_prev mod 2^CNT_W; done_prev<=DMA_DONE_CNT.
//   in_flight-=delta; FILLED+=delta; DONE_TOTAL+=delta. If delta>in_flight: clamp in_flight 0, set ERR.
//  Release: FILLED' = FILLED+delta-SW_RELEASE_CNT (same-cycle done and release both applied).
//   If the release exceeds FILLED+delta: FILLED'=0, ERR=1. Release ignored when SW_RELEASE=0.
//  Issue decision uses registered (pre-update) counters: one-cycle latency from done/release to next START.
//  STALL=1 in ISSUE when in_flight<CMD_DEPTH but ring full.
//  SRST or RST_N mid-operation: abort to IDLE immediately; outputs to reset values. The DMA engine is reset separately.
// TESTING
//  1 Reset, BASE=0, SIZE=972, NUM=4, cyclic=0, enable; DMA answers done after 100 cycles ->
//    START adrs 0,972,1944,2916; FINISHED=1; DONE_TOTAL=4; no 5th START.
//  2 cyclic=1, NUM=3, no release -> 3 STARTs; STALL=1, FILLED=3.
//    Release 1 -> next START at adr 0 within 2 cycles; WR_IDX=1.
//  3 CMD_DEPTH=2: done pulses delayed -> never >2 outstanding; STARTs separated by >=1 idle cycle.
//  4 DMA_DONE_CNT preset 16'hFFFF, two completions -> counter wraps to 1; DONE_TOTAL=2; ERR=0.
//  5 Release in same cycle as done with FILLED=1: release 2 -> FILLED=0, ERR=0. Release 3 -> FILLED=0, ERR=1.
//  6 Enable low with 1 outstanding -> DRAIN, no START, IDLE after done.
//    SRST mid-ISSUE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dma_ring_sched.sv
// Ring-buffer command scheduler for simple_dma: splits an SDRAM region into equal buffers,
// issues START commands with bounded outstanding depth and tracks completions against releases.
module dma_ring_sched #(
  parameter int ADDR_W    = 28,
  parameter int CNT_W     = 16,
  parameter int CMD_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst_i,
  input  logic              cfg_enable_i,
  input  logic              cfg_cyclic_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [ADDR_W-1:0] cfg_buf_size_i,
  input  logic [CNT_W-1:0]  cfg_num_bufs_i,
  input  logic              sw_release_i,
  input  logic [CNT_W-1:0]  sw_release_cnt_i,
  output logic              dma_start_o,
  output logic [ADDR_W-1:0] dma_start_adr_o,
  output logic [ADDR_W-1:0] dma_buf_size_o,
  input  logic [CNT_W-1:0]  dma_done_cnt_i,
  output logic [CNT_W-1:0]  filled_o,
  output logic [CNT_W-1:0]  wr_idx_o,
  output logic [CNT_W-1:0]  done_total_o,
  output logic              busy_o,
  output logic              finished_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(CMD_DEPTH);

  typedef struct packed {
    logic [2:0]        state;
    logic              en_prev;
    logic              primed;
    logic [CNT_W-1:0]  done_prev;
    logic              cyclic;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] buf_size;
    logic [ADDR_W-1:0] cur_adr;
    logic [ADDR_W-1:0] start_adr;
    logic              start;
    logic [CNT_W-1:0]  num_bufs;
    logic [CNT_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  in_flight;
    logic [CNT_W-1:0]  filled;
    logic [CNT_W-1:0]  done_total;
    logic              err;
  } regs_t;

  regs_t r_q, r_d;

  logic [CNT_W-1:0] delta;
  logic [CNT_W-1:0] inflight_after;
  logic [CNT_W:0]   filled_sum;
  logic             overrun;
  logic             over_release;
  logic             slot_free;
  logic             ring_room;
  logic             quota_left;
  logic             can_issue;
  logic             session_done;
  logic             start_edge;

  // The first cycle after reset only primes done_prev so a stale counter is not counted.
  assign delta          = r_q.primed ? (dma_done_cnt_i - r_q.done_prev) : '0;
  assign overrun        = delta > r_q.in_flight;
  assign inflight_after = overrun ? '0 : (r_q.in_flight - delta);
  assign filled_sum     = {1'b0, r_q.filled} + {1'b0, delta};
  assign over_release   = sw_release_i && ({1'b0, sw_release_cnt_i} > filled_sum);

  assign slot_free    = r_q.in_flight < DEPTH;
  assign ring_room    = ({1'b0, r_q.filled} + {1'b0, r_q.in_flight}) < {1'b0, r_q.num_bufs};
  assign quota_left   = r_q.cyclic || (r_q.issued < r_q.num_bufs);
  assign can_issue    = (r_q.state == S_ISSUE) && cfg_enable_i && slot_free && ring_room && quota_left;
  assign session_done = !r_q.cyclic && (r_q.done_total == r_q.num_bufs);
  assign start_edge   = (r_q.state == S_IDLE) && cfg_enable_i && !r_q.en_prev;

  always_comb begin
    // NOTE: start from the held value so every field has a default and no latch is inferred.
    r_d            = r_q;
    r_d.en_prev    = cfg_enable_i;
    r_d.primed     = 1'b1;
    r_d.done_prev  = dma_done_cnt_i;
    r_d.start      = can_issue;
    r_d.in_flight  = inflight_after + CNT_W'(can_issue);
    r_d.done_total = r_q.done_total + delta;
    if (over_release)
      r_d.filled = '0;
    else if (sw_release_i)
      r_d.filled = CNT_W'(filled_sum - {1'b0, sw_release_cnt_i});
    else
      r_d.filled = filled_sum[CNT_W-1:0];
    if (overrun || over_release)
      r_d.err = 1'b1;

    // Address walks by addition and snaps back to base on the last ring slot.
    if (can_issue) begin
      r_d.start_adr = r_q.cur_adr;
      r_d.issued    = r_q.issued + 1'b1;
      if (r_q.wr_idx == r_q.num_bufs - 1'b1) begin
        r_d.wr_idx  = '0;
        r_d.cur_adr = r_q.base;
      end else begin
        r_d.wr_idx  = r_q.wr_idx + 1'b1;
        r_d.cur_adr = r_q.cur_adr + r_q.buf_size;
      end
    end

    case (r_q.state)
      S_IDLE: begin
        if (start_edge) begin
          r_d.cyclic     = cfg_cyclic_i;
          r_d.base       = cfg_base_i;
          r_d.cur_adr    = cfg_base_i;
          r_d.buf_size   = cfg_buf_size_i;
          r_d.num_bufs   = cfg_num_bufs_i;
          r_d.wr_idx     = '0;
          r_d.issued     = '0;
          r_d.in_flight  = '0;
          r_d.filled     = '0;
          r_d.done_total = '0;
          r_d.err        = (cfg_num_bufs_i == '0);
          r_d.state      = (cfg_num_bufs_i == '0) ? S_IDLE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!cfg_enable_i)     r_d.state = S_DRAIN;
        else if (session_done) r_d.state = S_DONE;
        else if (can_issue)    r_d.state = S_GAP;
      end
      S_GAP: begin
        if (!cfg_enable_i)     r_d.state = S_DRAIN;
        else if (session_done) r_d.state = S_DONE;
        else                   r_d.state = S_ISSUE;
      end
      S_DRAIN: if (r_q.in_flight == '0) r_d.state = S_IDLE;
      S_DONE:  if (!cfg_enable_i)       r_d.state = S_IDLE;
      default: r_d.state = S_IDLE;
    endcase

    if (srst_i)
      r_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so all flops update together from pre-edge values.
    if (!rst_n) r_q <= '0;
    else        r_q <= r_d;
  end

  assign dma_start_o     = r_q.start;
  assign dma_start_adr_o = r_q.start_adr;
  assign dma_buf_size_o  = r_q.buf_size;
  assign filled_o        = r_q.filled;
  assign wr_idx_o        = r_q.wr_idx;
  assign done_total_o    = r_q.done_total;
  assign busy_o          = r_q.state != S_IDLE;
  assign finished_o      = r_q.state == S_DONE;
  assign stall_o         = (r_q.state == S_ISSUE) && slot_free && !ring_room && quota_left;
  assign err_o           = r_q.err;

endmodule

// File: tb/tb_dma_ring_sched.sv
// Directed bench for dma_ring_sched: depth-1 and depth-2 instances, each with a simple DMA latency model.
module tb_dma_ring_sched;
  localparam int AW = 28;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, srst, cyclic, rel1, en1, en2;
  logic [AW-1:0] base, size;
  logic [CW-1:0] num, rel_cnt;

  logic          start1, busy1, fin1, stall1, err1;
  logic [AW-1:0] adr1, bsz1;
  logic [CW-1:0] filled1, wr1, dtot1;
  logic          start2, busy2, fin2, stall2, err2;
  logic [AW-1:0] adr2, bsz2;
  logic [CW-1:0] filled2, wr2, dtot2;

  logic [CW-1:0] dbase1 = '0;
  logic [CW-1:0] comp1  = '0;
  logic [CW-1:0] comp2  = '0;
  logic [CW-1:0] done_cnt1, done_cnt2;
  assign done_cnt1 = dbase1 + comp1;
  assign done_cnt2 = comp2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat1  = 100;
  int lat2  = 20;
  bit auto1 = 1'b1;
  int q1[$];
  int q2[$];

  int n_start1 = 0;
  int n_start2 = 0;
  int last2    = 0;
  int min_gap2 = 1000;
  int max_out2 = 0;
  logic [AW-1:0] adr_log [64];

  dma_ring_sched #(.ADDR_W(AW), .CNT_W(CW), .CMD_DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .srst_i(srst), .cfg_enable_i(en1), .cfg_cyclic_i(cyclic),
    .cfg_base_i(base), .cfg_buf_size_i(size), .cfg_num_bufs_i(num),
    .sw_release_i(rel1), .sw_release_cnt_i(rel_cnt),
    .dma_start_o(start1), .dma_start_adr_o(adr1), .dma_buf_size_o(bsz1), .dma_done_cnt_i(done_cnt1),
    .filled_o(filled1), .wr_idx_o(wr1), .done_total_o(dtot1), .busy_o(busy1),
    .finished_o(fin1), .stall_o(stall1), .err_o(err1)
  );

  dma_ring_sched #(.ADDR_W(AW), .CNT_W(CW), .CMD_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .srst_i(srst), .cfg_enable_i(en2), .cfg_cyclic_i(cyclic),
    .cfg_base_i(base), .cfg_buf_size_i(size), .cfg_num_bufs_i(num),
    .sw_release_i(1'b0), .sw_release_cnt_i(16'd0),
    .dma_start_o(start2), .dma_start_adr_o(adr2), .dma_buf_size_o(bsz2), .dma_done_cnt_i(done_cnt2),
    .filled_o(filled2), .wr_idx_o(wr2), .done_total_o(dtot2), .busy_o(busy2),
    .finished_o(fin2), .stall_o(stall2), .err_o(err2)
  );

  // DMA models: each START completes a fixed number of cycles later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (auto1 && start1) q1.push_back(cyc + lat1);
    if (q1.size() > 0 && q1[0] <= cyc) begin
      void'(q1.pop_front());
      comp1 <= comp1 + 1'b1;
    end
    if (start2) q2.push_back(cyc + lat2);
    if (q2.size() > 0 && q2[0] <= cyc) begin
      void'(q2.pop_front());
      comp2 <= comp2 + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (start1) begin
      adr_log[n_start1[5:0]] <= adr1;
      n_start1 <= n_start1 + 1;
    end
    if (start2) begin
      n_start2 <= n_start2 + 1;
      last2    <= cyc;
      if (n_start2 > 0 && (cyc - last2) < min_gap2) min_gap2 <= cyc - last2;
      if ((n_start2 + 1 - int'(comp2)) > max_out2) max_out2 <= n_start2 + 1 - int'(comp2);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    int k;
    rst_n = 1'b0; srst = 1'b0; en1 = 1'b0; en2 = 1'b0; cyclic = 1'b0;
    base = '0; size = 28'd972; num = 16'd4; rel1 = 1'b0; rel_cnt = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_flags1", {busy1, fin1, stall1, err1, start1}, 0);
    check("rst_cnt1", {filled1, wr1, dtot1}, 0);
    check("rst_adr1", {adr1, bsz1}, 0);
    check("rst_dut2", {busy2, filled2, wr2, adr2, err2}, 0);

    // 1: non-cyclic ring of four, completions 100 cycles after each START
    en1 = 1'b1;
    for (int i = 0; i < 2000 && !fin1; i++) tick(1);
    check("t1_finished", fin1, 1);
    check("t1_done_total", dtot1, 4);
    check("t1_starts", n_start1, 4);
    check("t1_adr0", adr_log[0], 0);
    check("t1_adr1", adr_log[1], 972);
    check("t1_adr2", adr_log[2], 1944);
    check("t1_adr3", adr_log[3], 2916);
    check("t1_bufsize", bsz1, 972);
    tick(50);
    check("t1_no_fifth", n_start1, 4);
    en1 = 1'b0;
    tick(3);
    check("t1_idle", busy1, 0);

    // 2: cyclic ring of three with no release fills and stalls
    lat1 = 10; cyclic = 1'b1; num = 16'd3;
    s0 = n_start1;
    en1 = 1'b1;
    tick(100);
    check("t2_starts", n_start1 - s0, 3);
    check("t2_stall", stall1, 1);
    check("t2_filled", filled1, 3);
    check("t2_wr_idx_wrap", wr1, 0);
    rel1 = 1'b1; rel_cnt = 16'd1;
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      rel1 = 1'b0;
      if (start1) begin
        k = i;
        break;
      end
    end
    check("t2_release_latency", k, 2);
    check("t2_adr", adr1, 0);
    check("t2_wr_idx", wr1, 1);
    en1 = 1'b0;
    tick(30);
    check("t2_drain_idle", busy1, 0);

    // 3: depth-2 instance, completions 20 cycles after START
    num = 16'd8;
    en2 = 1'b1;
    tick(200);
    en2 = 1'b0;
    tick(60);
    check("t3_max_outstanding", max_out2, 2);
    check("t3_min_gap", min_gap2, 2);
    check("t3_idle", busy2, 0);

    // 4: done counter wraps from FFFF through 0 to 1
    lat1 = 5; cyclic = 1'b0; num = 16'd2;
    dbase1 = 16'hFFFF - comp1;
    tick(3);
    en1 = 1'b1;
    for (int i = 0; i < 200 && !fin1; i++) tick(1);
    check("t4_counter", done_cnt1, 1);
    check("t4_done_total", dtot1, 2);
    check("t4_err", err1, 0);
    check("t4_finished", fin1, 1);
    en1 = 1'b0;
    tick(3);

    // 5: releases coinciding with a completion, completions driven by hand
    auto1 = 1'b0; cyclic = 1'b1; num = 16'd4;
    en1 = 1'b1;
    tick(5);
    dbase1 = dbase1 + 1'b1;
    tick(5);
    check("t5_pre_filled", filled1, 1);
    dbase1 = dbase1 + 1'b1; rel1 = 1'b1; rel_cnt = 16'd2;
    tick(1);
    rel1 = 1'b0;
    check("t5_rel2_filled", filled1, 0);
    check("t5_rel2_err", err1, 0);
    tick(5);
    dbase1 = dbase1 + 1'b1;
    tick(5);
    dbase1 = dbase1 + 1'b1; rel1 = 1'b1; rel_cnt = 16'd3;
    tick(1);
    rel1 = 1'b0;
    check("t5_rel3_filled", filled1, 0);
    check("t5_rel3_err", err1, 1);

    // 6: enable drop with one command outstanding drains without issuing
    tick(5);
    s0 = n_start1;
    en1 = 1'b0;
    tick(10);
    check("t6_no_start", n_start1 - s0, 0);
    check("t6_drain_busy", busy1, 1);
    dbase1 = dbase1 + 1'b1;
    tick(3);
    check("t6_drain_idle", busy1, 0);

    // 6b: soft reset in the middle of a session
    base = 28'd100; cyclic = 1'b1; num = 16'd4;
    en1 = 1'b1;
    tick(4);
    check("srst_pre_wr", wr1, 1);
    srst = 1'b1; en1 = 1'b0;
    tick(1);
    check("srst_adr", {start1, adr1, bsz1}, 0);
    check("srst_state", {filled1, wr1, dtot1, busy1, fin1, stall1, err1}, 0);
    srst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
